// File: rtl/sym2bits_pkg.sv
// Shared types and helpers for the symbol-to-bit serializer.
package sym2bits_pkg;

  typedef enum logic {
    IDLE  = 1'b0,
    SHIFT = 1'b1
  } state_e;

  // A two-point constellation still carries one bit per symbol.
  function automatic int bits_per_symbol(input int order);
    return (order <= 2) ? 1 : $clog2(order);
  endfunction

endpackage

// File: rtl/sym2bits_fifo.sv
// Single-clock symbol FIFO; the parent guarantees push/pop are only asserted when legal.
module sym2bits_fifo #(
  parameter int WIDTH = 4,
  parameter int DEPTH = 4
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     push,
  input  logic                     pop,
  input  logic [WIDTH-1:0]         wdata,
  output logic [WIDTH-1:0]         rdata,
  output logic                     full,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   level
);

  localparam int AW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [WIDTH-1:0] mem_d [DEPTH];
  logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
  logic [AW-1:0]    rd_ptr_q, rd_ptr_d;
  logic [AW:0]      level_q, level_d;

  always_comb begin
    mem_d    = mem_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    level_d  = level_q;
    // Pointers are AW bits wide, so they wrap modulo DEPTH on their own.
    if (push) begin
      mem_d[wr_ptr_q] = wdata;
      wr_ptr_d        = wr_ptr_q + AW'(1);
    end
    if (pop) begin
      rd_ptr_d = rd_ptr_q + AW'(1);
    end
    case ({push, pop})
      2'b10:   level_d = level_q + (AW+1)'(1);
      2'b01:   level_d = level_q - (AW+1)'(1);
      default: level_d = level_q;
    endcase
  end

  always_ff @(posedge clk) begin
    mem_q <= mem_d;
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      level_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      level_q  <= level_d;
    end
  end

  assign rdata = mem_q[rd_ptr_q];
  assign full  = (level_q == (AW+1)'(DEPTH));
  assign empty = (level_q == '0);
  assign level = level_q;

endmodule

// File: rtl/sym2bits.sv
// Serializes buffered K-bit symbol indices into a ready/valid bit stream with SOP/EOP framing.
module sym2bits
  import sym2bits_pkg::*;
#(
  parameter int MODULATION_ORDER = 16,
  parameter int FIFO_DEPTH       = 4,
  parameter int MSB_FIRST        = 1,
  localparam int K               = bits_per_symbol(MODULATION_ORDER)
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic [K-1:0]                  i_binary_code,
  input  logic                          i_dv,
  output logic                          o_bit,
  output logic                          o_valid,
  input  logic                          i_ready,
  output logic                          o_sop,
  output logic                          o_eop,
  output logic                          o_overflow,
  output logic [$clog2(FIFO_DEPTH):0]   o_level
);

  localparam int CW = (K > 1) ? $clog2(K) : 1;

  state_e          state_q, state_d;
  logic [K-1:0]    shreg_q, shreg_d;
  logic [CW-1:0]   cnt_q, cnt_d;
  logic            ovf_q, ovf_d;

  logic            push, pop, xfer, last_bit;
  logic            fifo_full, fifo_empty;
  logic [K-1:0]    fifo_rdata;

  sym2bits_fifo #(
    .WIDTH (K),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk   (clk),
    .rst   (rst),
    .push  (push),
    .pop   (pop),
    .wdata (i_binary_code),
    .rdata (fifo_rdata),
    .full  (fifo_full),
    .empty (fifo_empty),
    .level (o_level)
  );

  always_comb begin
    xfer     = (state_q == SHIFT) && i_ready;
    last_bit = (cnt_q == CW'(K-1));
    // Reloading on the last transfer keeps back-to-back symbols bubble-free,
    // and a pop in the same cycle frees the slot for a push into a full FIFO.
    pop      = !fifo_empty && ((state_q == IDLE) || (xfer && last_bit));
    push     = i_dv && (!fifo_full || pop);

    state_d  = state_q;
    shreg_d  = shreg_q;
    cnt_d    = cnt_q;
    ovf_d    = ovf_q | (i_dv && !push);

    if (pop) begin
      state_d = SHIFT;
      shreg_d = fifo_rdata;
      cnt_d   = '0;
    end else if (xfer) begin
      if (last_bit) begin
        state_d = IDLE;
        cnt_d   = '0;
      end else begin
        cnt_d   = cnt_q + CW'(1);
        shreg_d = (MSB_FIRST != 0) ? (shreg_q << 1) : (shreg_q >> 1);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      shreg_q <= '0;
      cnt_q   <= '0;
      ovf_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      shreg_q <= shreg_d;
      cnt_q   <= cnt_d;
      ovf_q   <= ovf_d;
    end
  end

  assign o_valid    = (state_q == SHIFT);
  assign o_bit      = o_valid && ((MSB_FIRST != 0) ? shreg_q[K-1] : shreg_q[0]);
  assign o_sop      = o_valid && (cnt_q == '0);
  assign o_eop      = o_valid && last_bit;
  assign o_overflow = ovf_q;

endmodule

// File: doc/sym2bits.md
SYM2BITS -- requirements
Module: sym2bits

Interface
REQ-001 Parameter MODULATION_ORDER, default 16, constellation size; power of two, >= 2; K = $clog2(MODULATION_ORDER) bits per symbol.
REQ-002 Parameter FIFO_DEPTH, default 4, symbol buffer entries; power of two, >= 2.
REQ-003 Parameter MSB_FIRST, default 1, serial bit order: 1 = MSB first, 0 = LSB first.
REQ-004 clk  input  1  sole clock; all logic on rising edge.
REQ-005 rst  input  1  synchronous, active-high reset.
REQ-006 i_binary_code  input  K  binary symbol index from the upstream gray-to-binary stage.
REQ-007 i_dv  input  1  i_binary_code valid this cycle; no backpressure upstream.
REQ-008 o_bit  output  1  current serial bit.
REQ-009 o_valid  output  1  o_bit valid.
REQ-010 i_ready  input  1  downstream accepts o_bit when o_valid && i_ready.
REQ-011 o_sop  output  1  high with o_valid on the first bit of each symbol.
REQ-012 o_eop  output  1  high with o_valid on the last bit of each symbol.
REQ-013 o_overflow  output  1  sticky: a symbol was dropped.
REQ-014 o_level  output  $clog2(FIFO_DEPTH)+1  current FIFO occupancy.

Function
REQ-015 Datapath: input FIFO, then a K-bit shift register with bit counter; FSM states IDLE (shifter empty) and SHIFT (shifter loaded).
REQ-016 Push when i_dv && (FIFO not full || pop in same cycle); otherwise the symbol is dropped and o_overflow is set.
REQ-017 IDLE -> SHIFT when FIFO non-empty: pop head into shifter, counter = 0.
REQ-018 In SHIFT, o_valid = 1; a transfer (o_valid && i_ready) advances the counter and shifts one bit.
REQ-019 Transfer at counter K-1: pop the next symbol in the same cycle if the FIFO is non-empty (stay in SHIFT, no bubble); otherwise go to IDLE.
REQ-020 o_bit, o_sop and o_eop hold stable while o_valid && !i_ready.
REQ-021 Latency: i_dv at cycle N into an empty block gives o_valid and o_sop at N+2.
REQ-022 Throughput: one bit per cycle with i_ready held high; K cycles per symbol; symbols may arrive at most every K cycles without loss.
REQ-023 K = 1 (MODULATION_ORDER = 2): o_sop and o_eop are both high on every bit.
REQ-024 FIFO pointers wrap modulo FIFO_DEPTH; o_level is in 0..FIFO_DEPTH.
REQ-025 Total buffering is FIFO_DEPTH + 1 symbols (FIFO plus shifter).

Reset
REQ-026 On rst: state IDLE; FIFO empty; o_level = 0; o_valid, o_sop, o_eop, o_bit = 0; o_overflow cleared; counter = 0.
REQ-027 rst has priority over every event; a symbol in flight is discarded, and i_dv during rst is ignored.
REQ-028 First push is accepted in the cycle after rst deasserts.

Structure
REQ-029 Package sym2bits_pkg holds the bits_per_symbol() function and the state enum type (IDLE, SHIFT).
REQ-030 Sub-module sym2bits_fifo: synchronous single-clock FIFO with push, pop, full, empty and level.
REQ-031 Target size is 150-300 lines of RTL in total, with no combinational path from i_dv to any output.

Verification
REQ-032 M=16, MSB_FIRST=1, i_ready=1, symbol 4'b1011 at cycle 0 -> o_bit 1,0,1,1 at cycles 2-5; o_sop at cycle 2, o_eop at cycle 5.
REQ-033 Same stimulus with MSB_FIRST=0 -> o_bit 1,1,0,1.
REQ-034 Symbols 0xF then 0x0 every 4 cycles, with i_ready low on alternating cycles -> bit stream 1111 0000 with no loss or duplication; outputs stable while stalled.
REQ-035 i_ready=0 and 6 back-to-back symbols -> first 5 buffered (o_level peaks at 4); sixth dropped; o_overflow=1; after i_ready=1, exactly 20 bits are output.
REQ-036 rst pulsed at bit 2 of a symbol -> next cycle o_valid=0, o_level=0, o_overflow=0; a new symbol afterwards is serialized correctly.
REQ-037 M=2, symbols 1,0,1 on consecutive cycles with i_ready=1 -> o_bit 1,0,1 on consecutive cycles, o_sop and o_eop high on each bit.
